// File: rtl/ps2_dir_pkg.sv
// Shared scan codes, direction encoding and receiver state type for the PS/2 direction decoder.
package ps2_dir_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_REL   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receiver: synchronises the raw lines, detects ps2_clk falling edges and
// assembles 11-bit frames, abandoning a partial frame after TIMEOUT_CYCLES quiet cycles.
module ps2_rx_frame
    import ps2_dir_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic       clkSync1_q, clkSync2_q, clkPrev_q;
    logic       dataSync1_q, dataSync2_q;
    logic       fallEdge;

    rx_state_e   state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bitCnt_q;
    logic        parity_q;
    logic [CW-1:0] tmoCnt_q;
    logic        byteValid_q;
    logic        frameErr_q;

    // Both lines idle high, so the synchronisers preset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkSync1_q  <= 1'b1;
            clkSync2_q  <= 1'b1;
            clkPrev_q   <= 1'b1;
            dataSync1_q <= 1'b1;
            dataSync2_q <= 1'b1;
        end else begin
            clkSync1_q  <= ps2_clk_i;
            clkSync2_q  <= clkSync1_q;
            clkPrev_q   <= clkSync2_q;
            dataSync1_q <= ps2_data_i;
            dataSync2_q <= dataSync1_q;
        end
    end

    assign fallEdge = clkPrev_q & ~clkSync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_IDLE;
            shift_q     <= 8'd0;
            bitCnt_q    <= 3'd0;
            parity_q    <= 1'b0;
            tmoCnt_q    <= '0;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
            if (fallEdge) begin
                tmoCnt_q <= '0;
                case (state_q)
                    RX_IDLE: begin
                        if (!dataSync2_q) begin
                            state_q  <= RX_DATA;
                            bitCnt_q <= 3'd0;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        shift_q  <= {dataSync2_q, shift_q[7:1]};
                        bitCnt_q <= bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            state_q <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        parity_q <= dataSync2_q;
                        state_q  <= RX_STOP;
                    end
                    default: begin
                        state_q <= RX_IDLE;
                        // Odd parity: data plus parity bit must carry an odd number of ones.
                        if (dataSync2_q && ((^shift_q) ^ parity_q)) begin
                            byteValid_q <= 1'b1;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                    end
                endcase
            end else if (state_q != RX_IDLE) begin
                if (tmoCnt_q == TMO_LAST) begin
                    state_q    <= RX_IDLE;
                    tmoCnt_q   <= '0;
                    frameErr_q <= 1'b1;
                end else begin
                    tmoCnt_q <= tmoCnt_q + CW'(1);
                end
            end
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = byteValid_q;
    assign frame_err_o  = frameErr_q;

endmodule

// File: rtl/ps2_direction_decoder.sv
// Turns PS/2 arrow-key make/break codes into a held direction and a moving flag.
// Define WASD_KEYS_EN to also accept the non-extended W/A/S/D codes.
module ps2_direction_decoder
    import ps2_dir_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] direction,
    output logic       moving,
    output logic       frame_err
);

    logic [7:0] rxByte;
    logic       rxValid;
    logic       rxErr;

    logic       ext_q, rel_q;
    logic [1:0] direction_q;
    logic       moving_q;

    logic       keyHit;
    logic [1:0] keyDir;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .byte_o      (rxByte),
        .byte_valid_o(rxValid),
        .frame_err_o (rxErr)
    );

    always_comb begin
        keyHit = 1'b0;
        keyDir = DIR_UP;
        if (ext_q) begin
            case (rxByte)
                SC_UP:    begin keyHit = 1'b1; keyDir = DIR_UP;    end
                SC_LEFT:  begin keyHit = 1'b1; keyDir = DIR_LEFT;  end
                SC_DOWN:  begin keyHit = 1'b1; keyDir = DIR_DOWN;  end
                SC_RIGHT: begin keyHit = 1'b1; keyDir = DIR_RIGHT; end
                default:  ;
            endcase
        end else begin
`ifdef WASD_KEYS_EN
            case (rxByte)
                SC_W:    begin keyHit = 1'b1; keyDir = DIR_UP;    end
                SC_A:    begin keyHit = 1'b1; keyDir = DIR_LEFT;  end
                SC_S:    begin keyHit = 1'b1; keyDir = DIR_DOWN;  end
                SC_D:    begin keyHit = 1'b1; keyDir = DIR_RIGHT; end
                default: ;
            endcase
`else
            keyHit = 1'b0;
`endif
        end
    end

    // A break only stops motion for the key currently steering; direction itself is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            direction_q <= DIR_UP;
            moving_q    <= 1'b0;
        end else if (rxErr) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
        end else if (rxValid) begin
            if (rxByte == SC_EXT) begin
                ext_q <= 1'b1;
            end else if (rxByte == SC_REL) begin
                rel_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                rel_q <= 1'b0;
                if (keyHit) begin
                    if (!rel_q) begin
                        direction_q <= keyDir;
                        moving_q    <= 1'b1;
                    end else if (keyDir == direction_q) begin
                        moving_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign direction = direction_q;
    assign moving    = moving_q;
    assign frame_err = rxErr;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Scoreboard bench for ps2_direction_decoder: each sent byte queues the expected
// {direction, moving}; a monitor compares when a byte is accepted or frame_err pulses.
module tb_ps2_direction_decoder;

    localparam int HALF = 20;

    typedef struct packed {
        logic [1:0] dir;
        logic       mov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [1:0] direction;
    logic       moving;
    logic       frame_err;

    exp_t byteQ[$];
    exp_t errQ[$];
    int   checkCount = 0;
    int   passCount = 0;
    bit   byteSeen = 1'b0;
    exp_t monExp;

    ps2_direction_decoder #(
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .direction(direction),
        .moving   (moving),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] required);
        checkCount++;
        if (actual === required) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got {dir,mov}=%b, required %b at %0t", name, actual, required, $time);
        end
    endtask

    task automatic ps2Bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic goodParity,
                                 input logic [1:0] expDir, input logic expMov);
        logic par;
        exp_t e;
        par = ~^code;
        if (!goodParity) par = ~par;
        e.dir = expDir;
        e.mov = expMov;
        if (goodParity) byteQ.push_back(e);
        else errQ.push_back(e);
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(code[i]);
        ps2Bit(par);
        ps2Bit(1'b1);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge clk);
    endtask

    task automatic waitDrained(input int budget, input string name);
        int n;
        n = 0;
        while ((byteQ.size() != 0 || errQ.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput(name, {2'b00, (byteQ.size() == 0 && errQ.size() == 0)}, 3'b001);
    endtask

    // One clk after byte_valid the decoder has absorbed the byte.
    always @(negedge clk) begin
        if (byteSeen) begin
            if (byteQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_byte: got {dir,mov}=%b, required no accepted byte", {direction, moving});
            end else begin
                monExp = byteQ.pop_front();
                checkOutput("byte_response", {direction, moving}, monExp);
            end
        end
        byteSeen = dut.u_rx.byte_valid_o;
        if (frame_err === 1'b1) begin
            if (errQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_frame_err: got frame_err=1, required 0 at %0t", $time);
            end else begin
                monExp = errQ.pop_front();
                checkOutput("frame_err_response", {direction, moving}, monExp);
            end
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("in_reset", {direction, moving}, 3'b000);
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        checkOutput("idle_after_reset", {direction, moving}, 3'b000);

        // Left press
        applyStimulus(8'hE0, 1'b1, 2'd0, 1'b0);
        applyStimulus(8'h6B, 1'b1, 2'd1, 1'b1);

        // Right, override with down, release right (no effect), release down
        applyStimulus(8'hE0, 1'b1, 2'd1, 1'b1);
        applyStimulus(8'h74, 1'b1, 2'd3, 1'b1);
        applyStimulus(8'hE0, 1'b1, 2'd3, 1'b1);
        applyStimulus(8'h72, 1'b1, 2'd2, 1'b1);
        applyStimulus(8'hE0, 1'b1, 2'd2, 1'b1);
        applyStimulus(8'hF0, 1'b1, 2'd2, 1'b1);
        applyStimulus(8'h74, 1'b1, 2'd2, 1'b1);
        applyStimulus(8'hE0, 1'b1, 2'd2, 1'b1);
        applyStimulus(8'hF0, 1'b1, 2'd2, 1'b1);
        applyStimulus(8'h72, 1'b1, 2'd2, 1'b0);

        // Parity error drops ext, so a bare 75 afterwards is ignored
        applyStimulus(8'hE0, 1'b1, 2'd2, 1'b0);
        applyStimulus(8'h75, 1'b0, 2'd2, 1'b0);
        applyStimulus(8'h75, 1'b1, 2'd2, 1'b0);
        applyStimulus(8'hE0, 1'b1, 2'd2, 1'b0);
        applyStimulus(8'h75, 1'b1, 2'd0, 1'b1);
        waitDrained(100, "drain_after_parity");

        // Timeout: start bit plus four data bits, then silence
        errQ.push_back('{dir: 2'd0, mov: 1'b1});
        ps2Bit(1'b0);
        ps2Bit(1'b1);
        ps2Bit(1'b0);
        ps2Bit(1'b1);
        ps2Bit(1'b1);
        ps2_data = 1'b1;
        waitDrained(6000, "timeout_frame_err");
        repeat (10) @(posedge clk);
        applyStimulus(8'hE0, 1'b1, 2'd0, 1'b1);
        applyStimulus(8'h74, 1'b1, 2'd3, 1'b1);

        // WASD 'A' make and break
`ifdef WASD_KEYS_EN
        applyStimulus(8'h1C, 1'b1, 2'd1, 1'b1);
        applyStimulus(8'hF0, 1'b1, 2'd1, 1'b1);
        applyStimulus(8'h1C, 1'b1, 2'd1, 1'b0);
`else
        applyStimulus(8'h1C, 1'b1, 2'd3, 1'b1);
        applyStimulus(8'hF0, 1'b1, 2'd3, 1'b1);
        applyStimulus(8'h1C, 1'b1, 2'd3, 1'b1);
`endif
        waitDrained(100, "drain_after_wasd");

        // Reset in the middle of a frame, then a clean frame
        ps2Bit(1'b0);
        ps2Bit(1'b1);
        ps2Bit(1'b0);
        @(posedge clk);
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        checkOutput("midframe_reset", {direction, moving}, 3'b000);
        applyStimulus(8'hE0, 1'b1, 2'd0, 1'b0);
        applyStimulus(8'h6B, 1'b1, 2'd1, 1'b1);

        waitDrained(100, "final_drain");
        repeat (20) @(posedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
